// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM for the multicycle ARM datapath: fetch/decode/execute/memory/writeback
// with a memory ready handshake and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             ALUOp,
  output logic             LDRB,
  output logic             Retire,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  // Moore part of the outputs; in_fetch/in_decode/ldrb_en are later gated by MemReady, Op or Funct.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       in_fetch;
    logic       in_decode;
    logic       ldrb_en;
    logic       retire_fixed;
  } ctrl_t;

  state_t           state_reg, state_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] count_reg;
  logic             unused_funct;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
        c.result_src = 2'b10; c.in_fetch = 1'b1;
      end
      DECODE: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.in_decode = 1'b1;
      end
      MEMADR: c.alu_src_b = 2'b01;
      MEMRD: begin
        c.adr_src = 1'b1; c.mem_req = 1'b1; c.ldrb_en = 1'b1;
      end
      MEMWB: begin
        c.result_src = 2'b01; c.reg_w = 1'b1; c.ldrb_en = 1'b1; c.retire_fixed = 1'b1;
      end
      MEMWR: begin
        c.adr_src = 1'b1; c.mem_req = 1'b1; c.mem_w = 1'b1;
      end
      EXECR: c.alu_op = 1'b1;
      EXECI: begin
        c.alu_src_b = 2'b01; c.alu_op = 1'b1;
      end
      ALUWB: begin
        c.reg_w = 1'b1; c.retire_fixed = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10;
        c.branch = 1'b1; c.retire_fixed = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  if (MemReady) state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  if (MemReady) state_next = MEMWB;
      MEMWR:  if (MemReady) state_next = FETCH;
      EXECR, EXECI: state_next = ALUWB;
      default: state_next = FETCH;
    endcase
  end

  // Output flags are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      ctrl_reg  <= decode_state(FETCH);
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_state(state_next);
      if (Retire) count_reg <= count_reg + 1'b1;
    end
  end

  assign MemReq      = ctrl_reg.mem_req;
  assign AdrSrc      = ctrl_reg.adr_src;
  assign ALUSrcA     = ctrl_reg.alu_src_a;
  assign ALUSrcB     = ctrl_reg.alu_src_b;
  assign ResultSrc   = ctrl_reg.result_src;
  assign RegW        = ctrl_reg.reg_w;
  assign MemW        = ctrl_reg.mem_w;
  assign Branch      = ctrl_reg.branch;
  assign ALUOp       = ctrl_reg.alu_op;
  assign IRWrite     = ctrl_reg.in_fetch & MemReady;
  assign NextPC      = ctrl_reg.in_fetch & MemReady;
  assign LDRB        = ctrl_reg.ldrb_en & Funct[2];
  // A store retires on the cycle its write is accepted.
  assign Retire      = ctrl_reg.retire_fixed | (ctrl_reg.mem_w & MemReady);
  assign Illegal     = ctrl_reg.in_decode & (Op == 2'b11);
  assign RetireCount = count_reg;

  assign unused_funct = ^{Funct[4:3], Funct[1]};

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main sequencing state machine for the multicycle ARM datapath.
- Consumes the instruction-register fields Op and Funct and steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath mux selects and the unconditioned write enables (RegW, MemW, Branch, ALUOp), which the decode/conditional logic then gates.
- Adds a memory ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Op  in  2  instruction Op field (Instr[27:26]).
- Funct  in  6  instruction Funct field (Instr[25:20]). Bit 5 = I, bit 2 = B (byte), bit 0 = L/S.
- MemReady  in  1  memory has completed the current access this cycle.
- MemReq  out  1  memory access in progress.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  PC update at fetch.
- AdrSrc  out  1  0 = PC address, 1 = ALU result address.
- ALUSrcA  out  2  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ResultSrc  out  2  result mux select.
- RegW  out  1  register write, unconditioned.
- MemW  out  1  memory write, unconditioned.
- Branch  out  1  branch, unconditioned.
- ALUOp  out  1  enable ALU decoder (data-processing instruction).
- LDRB  out  1  byte load, zero-extend.
- Retire  out  1  one-cycle pulse on an instruction's final cycle.
- Illegal  out  1  one-cycle pulse when Op = 11 is decoded.
- RetireCount  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- State register and counter reset asynchronously on reset = 0. State resets to FETCH; RetireCount resets to 0.
- Outputs are Moore decodes of the state, except where noted as gated by MemReady or Funct.
- Outputs in reset hold FETCH values with MemReady = 0: MemReq = 1, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, all other outputs 0.
- Unlisted outputs are 0 in every state. ALUSrcA/ALUSrcB/ResultSrc default to 00.
- FETCH: AdrSrc = 0, MemReq = 1, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10.
  - IRWrite = NextPC = MemReady.
  - Stays in FETCH while MemReady = 0; goes to DECODE when MemReady = 1.
- DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10. Next state:
  - Op = 01 → MEMADR.
  - Op = 00 and Funct[5] = 1 → EXECI.
  - Op = 00 and Funct[5] = 0 → EXECR.
  - Op = 10 → BRANCH.
  - Op = 11 → FETCH, with Illegal = 1 for this cycle and no Retire.
- MEMADR: ALUSrcA = 00, ALUSrcB = 01. Funct[0] = 1 → MEMRD; Funct[0] = 0 → MEMWR.
- MEMRD: AdrSrc = 1, MemReq = 1, LDRB = Funct[2]. Waits for MemReady, then goes to MEMWB.
- MEMWB: ResultSrc = 01, RegW = 1, LDRB = Funct[2], Retire = 1. Next state FETCH.
- MEMWR: AdrSrc = 1, MemReq = 1, MemW = 1.
  - MemW is held for every cycle until MemReady = 1; the state is left on that cycle.
  - Retire = MemReady. Next state FETCH.
- EXECR: ALUSrcA = 00, ALUSrcB = 00, ALUOp = 1. Next state ALUWB.
- EXECI: ALUSrcA = 00, ALUSrcB = 01, ALUOp = 1. Next state ALUWB.
- ALUWB: ResultSrc = 00, RegW = 1, Retire = 1. Next state FETCH. CMP suppression is not done here; it is the downstream NoWrite's job.
- BRANCH: ALUSrcA = 10, ALUSrcB = 01, ResultSrc = 10, Branch = 1, Retire = 1. Next state FETCH.
- Cycle counts with zero-wait memory (MemReady tied 1):
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle of MemReady = 0 in FETCH, MEMRD or MEMWR adds one cycle. No timeout.
- RetireCount increments by 1 on each clock edge where Retire = 1, and wraps from 2^CNT_W − 1 to 0.
- Op and Funct must be sampled only in DECODE, MEMADR, MEMRD and MEMWB, where the instruction register is stable. They are ignored in other states.
- Reset asserted mid-instruction (any state, including a MemW hold) aborts immediately. MemW, RegW and MemReq drop to reset values asynchronously, and the counter clears.
- MemReady asserted in a state that does not use it has no effect.

Test Plan:
- Reset, then MemReady = 1 with an ADD register instruction (Op = 00, Funct = 001000) → states FETCH, DECODE, EXECR, ALUWB, FETCH. ALUOp = 1 in EXECR; RegW = 1 and Retire = 1 in ALUWB; RetireCount = 1.
- LDRB (Op = 01, Funct = 000101), MemReady low for 2 cycles in MEMRD → MEMRD lasts 3 cycles. LDRB = 1 in MEMRD and MEMWB; RegW only in MEMWB; total 7 cycles.
- STR (Op = 01, Funct = 000000), MemReady low for 3 cycles in MEMWR → MemW = 1 for exactly 4 cycles; Retire pulses on the 4th; then FETCH.
- Branch (Op = 10) with FETCH stalled 1 cycle → IRWrite/NextPC only on the ready cycle. Branch = 1 for one cycle, ALUSrcA = 10, ALUSrcB = 01.
- Op = 11 → Illegal pulse in DECODE; back to FETCH; RetireCount unchanged.
- Assert reset = 0 during MEMWR with MemW = 1 → MemW falls without a clock edge; state FETCH and RetireCount = 0 on release. Separately, with CNT_W = 4, 16 retires → count wraps to 0.
